// File: rtl/psram_arbiter.sv
// Two-port psram arbiter: high-priority video reads and host reads/writes share one
// psram controller through its stb/busy handshake, with a bounded video run and a transaction timeout.
module psram_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int MAX_VID_RUN = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_v_req,
  input  logic [ADDR_W-1:0] i_v_addr,
  output logic              o_v_ack,
  output logic [DATA_W-1:0] o_v_dout,
  input  logic              i_h_req,
  input  logic              i_h_we,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_din,
  output logic              o_h_ack,
  output logic [DATA_W-1:0] o_h_dout,
  output logic              o_ps_stb,
  output logic              o_ps_we,
  output logic [ADDR_W-1:0] o_ps_addr,
  output logic [DATA_W-1:0] o_ps_din,
  input  logic              i_ps_busy,
  input  logic [DATA_W-1:0] i_ps_dout,
  output logic              o_owner,
  output logic              o_active,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int              RUN_W   = $clog2(MAX_VID_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);
  localparam logic [7:0]       TMO_MAX = 8'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q;
  logic [7:0]       tmo_q;
  logic             grant, grant_host, done, abort;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    grant      = 1'b0;
    grant_host = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Busy high here means psram is still starting up or recovering from an abort.
        if (!i_ps_busy && (i_v_req || i_h_req)) begin
          grant      = 1'b1;
          grant_host = i_h_req && (!i_v_req || run_q == RUN_MAX);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_ps_busy) begin
          state_d = S_WAIT;
        end else if (tmo_q == TMO_MAX) begin
          abort   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (!i_ps_busy) begin
          done    = 1'b1;
          state_d = S_RESP;
        end else if (tmo_q == TMO_MAX) begin
          abort   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      tmo_q     <= '0;
      o_v_ack   <= 1'b0;
      o_v_dout  <= '0;
      o_h_ack   <= 1'b0;
      o_h_dout  <= '0;
      o_ps_stb  <= 1'b0;
      o_ps_we   <= 1'b0;
      o_ps_addr <= '0;
      o_ps_din  <= '0;
      o_owner   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      state_q   <= state_d;
      o_v_ack   <= 1'b0;
      o_h_ack   <= 1'b0;
      o_timeout <= 1'b0;

      // Video run length only matters while the host is actually waiting.
      if (!i_h_req)
        run_q <= '0;
      else if (grant && grant_host)
        run_q <= '0;
      else if (grant && run_q != RUN_MAX)
        run_q <= run_q + RUN_W'(1);

      if (state_q == S_ISSUE || state_q == S_WAIT)
        tmo_q <= tmo_q + 8'd1;

      if (grant) begin
        o_owner   <= grant_host;
        o_ps_stb  <= 1'b1;
        o_ps_we   <= grant_host & i_h_we;
        o_ps_addr <= grant_host ? i_h_addr : i_v_addr;
        o_ps_din  <= grant_host ? i_h_din : '0;
        tmo_q     <= '0;
      end

      if (state_q == S_ISSUE && i_ps_busy) begin
        o_ps_stb <= 1'b0;
        o_ps_we  <= 1'b0;
      end

      if (done) begin
        if (o_owner) o_h_dout <= i_ps_dout;
        else         o_v_dout <= i_ps_dout;
      end

      if (abort) begin
        o_ps_stb  <= 1'b0;
        o_ps_we   <= 1'b0;
        o_timeout <= 1'b1;
        if (o_owner) o_h_dout <= '1;
        else         o_v_dout <= '1;
      end

      if (done || abort) begin
        o_v_ack <= !o_owner;
        o_h_ack <= o_owner;
      end
    end
  end

  assign o_active = (state_q != S_IDLE);

endmodule
